// File: rtl/serial_tx.sv
// Parallel-in, serial-out frame transmitter: start bit, WIDTH data bits LSB
// first, optional parity bit, stop bit, with every bit held for DIV clocks.
//
// state   | meaning
// S_IDLE  | line high, ready for a load
// S_START | start bit (txd low)
// S_DATA  | data bits, shift register LSB on the line
// S_PAR   | parity bit (only when PARITY != 0)
// S_STOP  | stop bit (txd high), done on its last clock
module serial_tx #(
    parameter int WIDTH  = 8,
    parameter int DIV    = 4,
    parameter int PARITY = 0
) (
    input  logic             c,
    input  logic             rn,
    input  logic [WIDTH-1:0] din,
    input  logic             load,
    output logic             ready,
    output logic             txd,
    output logic             done
);
    localparam int DW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int BW = $clog2(WIDTH + 1);
    localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH - 1);

    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PAR, S_STOP} state_t;

    state_t           state_q, state_d;
    logic [DW-1:0]    div_q, div_d;
    logic [BW-1:0]    bit_q, bit_d;
    logic [WIDTH-1:0] shift_q, shift_d, shift_nxt;
    logic             par_q, par_d;
    logic             ready_q, ready_d;
    logic             txd_q, txd_d;
    logic             done_q, done_d;
    logic             tc;

    assign tc        = (div_q == DIV_LAST);
    assign shift_nxt = shift_q >> 1;

    always_comb begin
        state_d = state_q;
        div_d   = div_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        par_d   = par_q;
        ready_d = ready_q;
        txd_d   = txd_q;
        case (state_q)
            S_IDLE: begin
                txd_d   = 1'b1;
                ready_d = 1'b1;
                if (load) begin
                    shift_d = din;
                    par_d   = (^din) ^ (PARITY == 2);
                    bit_d   = '0;
                    div_d   = '0;
                    state_d = S_START;
                    txd_d   = 1'b0;
                    ready_d = 1'b0;
                end
            end
            S_START: begin
                if (tc) begin
                    div_d   = '0;
                    state_d = S_DATA;
                    txd_d   = shift_q[0];
                end else begin
                    div_d = div_q + 1'b1;
                end
            end
            S_DATA: begin
                if (tc) begin
                    div_d   = '0;
                    shift_d = shift_nxt;
                    bit_d   = bit_q + 1'b1;
                    if (bit_q == BIT_LAST) begin
                        if (PARITY != 0) begin
                            state_d = S_PAR;
                            txd_d   = par_q;
                        end else begin
                            state_d = S_STOP;
                            txd_d   = 1'b1;
                        end
                    end else begin
                        txd_d = shift_nxt[0];
                    end
                end else begin
                    div_d = div_q + 1'b1;
                end
            end
            S_PAR: begin
                if (tc) begin
                    div_d   = '0;
                    state_d = S_STOP;
                    txd_d   = 1'b1;
                end else begin
                    div_d = div_q + 1'b1;
                end
            end
            S_STOP: begin
                if (tc) begin
                    div_d   = '0;
                    state_d = S_IDLE;
                    txd_d   = 1'b1;
                    ready_d = 1'b1;
                end else begin
                    div_d = div_q + 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
                div_d   = '0;
                txd_d   = 1'b1;
                ready_d = 1'b1;
            end
        endcase
        // done is registered, so flag the cycle that will be the last of STOP
        done_d = (state_d == S_STOP) && (div_d == DIV_LAST);
    end

    always_ff @(posedge c) begin
        if (!rn) begin
            state_q <= S_IDLE;
            div_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            par_q   <= 1'b0;
            ready_q <= 1'b1;
            txd_q   <= 1'b1;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            par_q   <= par_d;
            ready_q <= ready_d;
            txd_q   <= txd_d;
            done_q  <= done_d;
        end
    end

    assign ready = ready_q;
    assign txd   = txd_q;
    assign done  = done_q;

endmodule
